// File: rtl/usb1bd_pa_tx.sv
// USB1.1 device packet assembler (UTMI TX side): sends handshake PIDs and
// data packets (PID, payload, CRC16) from a protocol-engine byte stream.
module usb1bd_pa_tx #(
  parameter int MAX_PLEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_token,
  input  logic [1:0] token_pid_sel,
  input  logic       send_data,
  input  logic [1:0] data_pid_sel,
  input  logic       send_zlen,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  input  logic       src_last,
  output logic       src_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       underrun,
  output logic       len_err
);

  // state  | meaning
  // IDLE   | waiting for a send request
  // PID    | PID byte on the bus, payload prefetch running
  // DATA   | payload bytes from the holding register
  // CRC_LO | low CRC byte on the bus
  // CRC_HI | high CRC byte on the bus
  localparam int CW = $clog2(MAX_PLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    pid_byte;
  logic          is_token;
  logic          zlen;
  logic [7:0]    hold;
  logic          hold_last;
  logic          hold_full;
  logic          src_done;
  logic [CW-1:0] cnt;
  logic [CW-1:0] fcnt;
  logic [15:0]   crc;
  logic [15:0]   crc_tx;
  logic          accept;
  logic          take;
  logic          consume;
  logic          fetch_ok;
  logic          done_ev;
  logic          under_ev;
  logic          len_ev;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  function automatic logic [7:0] pid_of(input logic [3:0] p);
    return {~p, p};
  endfunction

  function automatic logic [3:0] token_code(input logic [1:0] sel);
    logic [3:0] p;
    case (sel)
      2'd0:    p = 4'h2;
      2'd1:    p = 4'hA;
      2'd2:    p = 4'hE;
      default: p = 4'h6;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] data_code(input logic [1:0] sel);
    logic [3:0] p;
    case (sel)
      2'd0:    p = 4'h3;
      2'd1:    p = 4'hB;
      2'd2:    p = 4'h7;
      default: p = 4'hF;
    endcase
    return p;
  endfunction

  // Wire CRC is the complemented, bit-reversed shift register.
  always_comb begin
    crc_tx = '0;
    for (int i = 0; i < 16; i++) crc_tx[i] = ~crc[15-i];
  end

  assign accept  = (state == S_IDLE) && (send_token || send_data);
  assign take    = src_valid && src_ready;
  assign consume = (state == S_DATA) && hold_full && tx_ready;
  // Stop fetching once the final byte or the length limit has been taken.
  assign fetch_ok = !is_token && !zlen && !src_done && (fcnt != CW'(MAX_PLEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_ev  = 1'b0;
    under_ev = 1'b0;
    len_ev   = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_PID;
      S_PID: begin
        if (tx_ready) begin
          if (is_token) begin
            state_nx = S_IDLE;
            done_ev  = 1'b1;
          end else if (zlen) begin
            state_nx = S_CRC_LO;
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (consume) begin
          if (hold_last) begin
            state_nx = S_CRC_LO;
          end else if (cnt == CW'(MAX_PLEN - 1)) begin
            state_nx = S_CRC_LO;
            len_ev   = 1'b1;
          end
        end else if (!hold_full && !take) begin
          state_nx = S_IDLE;
          under_ev = 1'b1;
        end
      end
      S_CRC_LO: if (tx_ready) state_nx = S_CRC_HI;
      S_CRC_HI: begin
        if (tx_ready) begin
          state_nx = S_IDLE;
          done_ev  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    src_ready = 1'b0;
    tx_busy   = (state != S_IDLE);
    case (state)
      S_PID: begin
        tx_data   = pid_byte;
        tx_valid  = 1'b1;
        src_ready = fetch_ok && !hold_full;
      end
      S_DATA: begin
        tx_data   = hold;
        tx_valid  = hold_full;
        // A byte leaving the holder this cycle frees it for a same-cycle refill.
        src_ready = fetch_ok && (!hold_full || tx_ready);
      end
      S_CRC_LO: begin
        tx_data  = crc_tx[7:0];
        tx_valid = 1'b1;
      end
      S_CRC_HI: begin
        tx_data  = crc_tx[15:8];
        tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_byte  <= 8'h00;
      is_token  <= 1'b0;
      zlen      <= 1'b0;
      hold      <= 8'h00;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      src_done  <= 1'b0;
      cnt       <= '0;
      fcnt      <= '0;
      crc       <= 16'hFFFF;
    end else if (accept) begin
      is_token  <= send_token;
      zlen      <= !send_token && send_zlen;
      pid_byte  <= send_token ? pid_of(token_code(token_pid_sel))
                              : pid_of(data_code(data_pid_sel));
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      src_done  <= 1'b0;
      cnt       <= '0;
      fcnt      <= '0;
      crc       <= 16'hFFFF;
    end else begin
      if (take) begin
        hold      <= src_data;
        hold_last <= src_last;
        hold_full <= 1'b1;
        fcnt      <= (fcnt == CW'(MAX_PLEN)) ? fcnt : fcnt + 1'b1;
        if (src_last) src_done <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
      if (consume) begin
        crc <= crc16_byte(crc, hold);
        cnt <= (cnt == CW'(MAX_PLEN)) ? cnt : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_done  <= 1'b0;
      underrun <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      tx_done  <= done_ev;
      underrun <= under_ev;
      len_err  <= len_ev;
    end
  end

endmodule

// File: tb/tb_usb1bd_pa_tx.sv
// Bench for usb1bd_pa_tx: drives requests and a byte source, captures the
// UTMI byte stream and compares it with a packet model built from USB rules.
module tb_usb1bd_pa_tx;

  logic       clk, rst;
  logic       send_token, send_data, send_zlen;
  logic [1:0] token_pid_sel, data_pid_sel;
  logic [7:0] src_data;
  logic       src_valid, src_last, tx_ready;
  logic       sel4;

  logic [7:0] a_tx_data, b_tx_data, m_tx_data;
  logic a_src_ready, a_tx_valid, a_tx_busy, a_tx_done, a_underrun, a_len_err;
  logic b_src_ready, b_tx_valid, b_tx_busy, b_tx_done, b_underrun, b_len_err;
  logic m_src_ready, m_tx_valid, m_tx_busy, m_tx_done, m_underrun, m_len_err;

  usb1bd_pa_tx #(.MAX_PLEN(64)) dut_a (
    .clk(clk), .rst(rst),
    .send_token(send_token && !sel4), .token_pid_sel(token_pid_sel),
    .send_data(send_data && !sel4), .data_pid_sel(data_pid_sel), .send_zlen(send_zlen),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(a_src_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .tx_busy(a_tx_busy), .tx_done(a_tx_done), .underrun(a_underrun), .len_err(a_len_err));

  usb1bd_pa_tx #(.MAX_PLEN(4)) dut_b (
    .clk(clk), .rst(rst),
    .send_token(send_token && sel4), .token_pid_sel(token_pid_sel),
    .send_data(send_data && sel4), .data_pid_sel(data_pid_sel), .send_zlen(send_zlen),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last), .src_ready(b_src_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .tx_busy(b_tx_busy), .tx_done(b_tx_done), .underrun(b_underrun), .len_err(b_len_err));

  assign m_tx_data   = sel4 ? b_tx_data   : a_tx_data;
  assign m_src_ready = sel4 ? b_src_ready : a_src_ready;
  assign m_tx_valid  = sel4 ? b_tx_valid  : a_tx_valid;
  assign m_tx_busy   = sel4 ? b_tx_busy   : a_tx_busy;
  assign m_tx_done   = sel4 ? b_tx_done   : a_tx_done;
  assign m_underrun  = sel4 ? b_underrun  : a_underrun;
  assign m_len_err   = sel4 ? b_len_err   : a_len_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails;
  logic [7:0] src_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int plen_g, offer_g, src_idx;
  int valid_cycles, last_cyc, done_cyc, extra_done;
  logic seen_done, seen_under, seen_len, seen_sready;
  logic [7:0] tok_pid [4];
  logic [7:0] dat_pid [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reflected form of the USB CRC16 (poly 0xA001, LSB first).
  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {8'h00, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  task automatic prep(input int plen, input int offer, input logic ramp);
    src_q.delete(); rx_q.delete();
    for (int i = 0; i < offer; i++) src_q.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    plen_g = plen; offer_g = offer; src_idx = 0;
    valid_cycles = 0; last_cyc = -10; done_cyc = -20; extra_done = 0;
    seen_done = 0; seen_under = 0; seen_len = 0; seen_sready = 0;
  endtask

  task automatic start(input logic tok, input logic dat, input logic [1:0] ts,
                       input logic [1:0] ds, input logic zl);
    @(negedge clk);
    send_token = tok; send_data = dat; token_pid_sel = ts; data_pid_sel = ds; send_zlen = zl;
    @(posedge clk); #1;
    send_token = 0; send_data = 0; send_zlen = 0;
  endtask

  task automatic run(input int max_cyc, input int mode, input logic need_end);
    logic pv, pr;
    logic [7:0] pd;
    pv = 0; pr = 0; pd = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      tx_ready  = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : ($urandom_range(0, 2) != 0);
      src_valid = (src_idx < offer_g);
      src_data  = (src_idx < offer_g) ? src_q[src_idx] : 8'h00;
      src_last  = (src_idx < offer_g) && (src_idx == plen_g - 1);
      #1;
      if (pv && !pr) begin
        chk("stall_valid", m_tx_valid, 1);
        chk("stall_data", m_tx_data, pd);
      end
      if (m_src_ready) seen_sready = 1;
      if (m_tx_valid) valid_cycles++;
      if (m_tx_valid && tx_ready) begin rx_q.push_back(m_tx_data); last_cyc = c; end
      if (m_tx_done) begin seen_done = 1; done_cyc = c; end
      if (m_underrun) seen_under = 1;
      if (m_len_err) seen_len = 1;
      if (src_valid && m_src_ready) src_idx++;
      pv = m_tx_valid; pr = tx_ready; pd = m_tx_data;
      if (seen_done || seen_under) break;
    end
    if (need_end) chk("timeout", seen_done || seen_under, 1);
  endtask

  task automatic tail();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_ready = 1; src_valid = 0; src_last = 0;
      #1;
      if (m_tx_done) extra_done++;
    end
  endtask

  task automatic check_pkt(input string tag, input logic tok, input logic [7:0] pid,
                           input logic zl, input int maxp);
    int n;
    logic [15:0] c;
    exp_q.delete();
    exp_q.push_back(pid);
    if (!tok) begin
      n = zl ? 0 : ((plen_g < maxp) ? plen_g : maxp);
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin exp_q.push_back(src_q[i]); c = crc_step(c, src_q[i]); end
      c = ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
    chk($sformatf("%s_nbytes", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    chk($sformatf("%s_done", tag), seen_done, 1);
    chk($sformatf("%s_under", tag), seen_under, 0);
    chk($sformatf("%s_lenerr", tag), seen_len, !tok && !zl && (plen_g > maxp));
    chk($sformatf("%s_done_time", tag), done_cyc, last_cyc + 1);
    chk($sformatf("%s_extra_done", tag), extra_done, 0);
    if (tok || zl) chk($sformatf("%s_no_src", tag), seen_sready, 0);
  endtask

  initial begin
    logic [15:0] r;
    int plen, ds;
    tests = 0; fails = 0;
    tok_pid = '{8'hD2, 8'h5A, 8'h1E, 8'h96};
    dat_pid = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    send_token = 0; send_data = 0; send_zlen = 0; token_pid_sel = 0; data_pid_sel = 0;
    src_data = 0; src_valid = 0; src_last = 0; tx_ready = 1; sel4 = 0;
    rst = 1;
    #12;
    chk("rst_tx_valid", m_tx_valid, 0);
    chk("rst_tx_busy", m_tx_busy, 0);
    chk("rst_tx_data", m_tx_data, 8'h00);
    chk("rst_src_ready", m_src_ready, 0);
    chk("rst_pulses", {m_tx_done, m_underrun, m_len_err}, 3'b000);
    @(negedge clk); rst = 0;

    // ACK with the UTMI always ready: one PID cycle then tx_done.
    prep(0, 0, 0); start(1, 0, 2'd0, 2'd0, 0); run(50, 0, 1); tail();
    check_pkt("ack", 1, tok_pid[0], 0, 64);
    chk("ack_one_cycle", valid_cycles, 1);

    for (int s = 0; s < 4; s++) begin
      prep(0, 0, 0); start(1, 0, 2'(s), 2'd0, 0); run(50, 2, 1); tail();
      check_pkt($sformatf("tok%0d", s), 1, tok_pid[s], 0, 64);
    end

    prep(0, 0, 0); start(0, 1, 2'd0, 2'd1, 1); run(50, 0, 1); tail();
    check_pkt("zlen", 0, dat_pid[1], 1, 64);

    // DATA0 00..03 under a toggling tx_ready, plus receiver residue check.
    prep(4, 4, 1); start(0, 1, 2'd0, 2'd0, 0); run(100, 1, 1); tail();
    check_pkt("d0ramp", 0, dat_pid[0], 0, 64);
    r = 16'hFFFF;
    for (int i = 1; i < rx_q.size(); i++) r = crc_step(r, rx_q[i]);
    chk("d0ramp_residue", r, 16'hB001);

    for (int k = 0; k < 6; k++) begin
      plen = $urandom_range(1, 20); ds = $urandom_range(0, 3);
      prep(plen, plen, 0); start(0, 1, 2'd0, 2'(ds), 0); run(400, 2, 1); tail();
      check_pkt($sformatf("rnd%0d", k), 0, dat_pid[ds], 0, 64);
    end

    // Source dries up after two of four bytes.
    prep(4, 2, 1); start(0, 1, 2'd0, 2'd0, 0); run(100, 0, 1);
    chk("under_seen", seen_under, 1);
    chk("under_valid", m_tx_valid, 0);
    chk("under_busy", m_tx_busy, 0);
    tail();
    chk("under_nbytes", rx_q.size(), 3);
    chk("under_no_done", seen_done || (extra_done != 0), 0);

    // Length limit on the MAX_PLEN=4 instance.
    sel4 = 1;
    prep(6, 6, 0); start(0, 1, 2'd0, 2'd2, 0); run(200, 2, 1); tail();
    check_pkt("max4_trunc", 0, dat_pid[2], 0, 4);
    chk("max4_src_taken", src_idx, 4);
    prep(4, 4, 0); start(0, 1, 2'd0, 2'd3, 0); run(200, 2, 1); tail();
    check_pkt("max4_exact", 0, dat_pid[3], 0, 4);
    sel4 = 0;

    prep(3, 3, 0); start(1, 1, 2'd1, 2'd0, 0); run(50, 2, 1); tail();
    check_pkt("both_req", 1, tok_pid[1], 0, 64);

    // Reset in the middle of the payload.
    prep(10, 10, 0); start(0, 1, 2'd0, 2'd1, 0); run(4, 0, 0);
    chk("mid_busy", m_tx_busy, 1);
    rst = 1; #1;
    chk("mid_rst_valid", m_tx_valid, 0);
    chk("mid_rst_busy", m_tx_busy, 0);
    chk("mid_rst_src_ready", m_src_ready, 0);
    chk("mid_rst_data", m_tx_data, 8'h00);
    @(negedge clk); rst = 0;
    tail();
    chk("mid_rst_no_done", extra_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
